// File: rtl/ram_bridge.sv
// Bridges the top-level flat RAM bus to a req/ack 16-bit word memory port, splitting misaligned words.
// Optional ROM write protection is enabled by defining RAM_BRIDGE_WRPROT_EN.
module ram_bridge #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [19:0] ROM_BASE = 20'hE0000
) (
  input  logic        FCLK,
  input  logic        RESETL,
  input  logic [19:0] ABus,
  input  logic        Write,
  input  logic        Word,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  output logic        Busy,
  output logic        TimeoutP,
  output logic        MemReq,
  input  logic        MemAck,
  output logic [18:0] MemAddr,
  output logic        MemWE,
  output logic [1:0]  MemBE,
  output logic [15:0] MemWData,
  input  logic [15:0] MemRData
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_DONE, S_ABORT} state_e;

  state_e             state_q, state_d;
  logic [37:0]        last_q, last_d;
  logic               lastValid_q, lastValid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        rdBuf_q, rdBuf_d;
  logic [15:0]        rdData_q, rdData_d;

  logic [37:0] busTuple;
  logic [19:0] addrQ;
  logic        writeQ, wordQ, misaligned, startAcc;
  logic [15:0] wdataQ;
  logic [19:0] phByteAddr;
  logic        inRom, wrProt;

  // The latched "last" tuple doubles as the descriptor of the access in flight.
  assign busTuple   = {ABus, Write, Word, WrData & {16{Write}}};
  assign addrQ      = last_q[37:18];
  assign writeQ     = last_q[17];
  assign wordQ      = last_q[16];
  assign wdataQ     = last_q[15:0];
  assign misaligned = wordQ & addrQ[0];
  assign startAcc   = !lastValid_q || (busTuple != last_q);

  assign phByteAddr = (state_q == S_PH2) ? {addrQ[19:1] + 19'd1, 1'b0} : addrQ;
  assign inRom      = (phByteAddr >= ROM_BASE);
`ifdef RAM_BRIDGE_WRPROT_EN
  assign wrProt = writeQ & inRom;
`else
  assign wrProt = 1'b0 & inRom;
`endif

  assign Busy     = (state_q != S_IDLE);
  assign TimeoutP = (state_q == S_ABORT);
  assign RdData   = rdData_q;

  always_ff @(posedge FCLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q     <= S_IDLE;
      last_q      <= '0;
      lastValid_q <= 1'b0;
      cnt_q       <= '0;
      rdBuf_q     <= '0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lastValid_q <= lastValid_d;
      cnt_q       <= cnt_d;
      rdBuf_q     <= rdBuf_d;
      rdData_q    <= rdData_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    lastValid_d = lastValid_q;
    cnt_d       = '0;
    rdBuf_d     = rdBuf_q;
    rdData_d    = rdData_q;
    unique case (state_q)
      S_IDLE: begin
        if (startAcc) begin
          state_d     = S_PH1;
          last_d      = busTuple;
          lastValid_d = 1'b1;
        end
      end
      S_PH1: begin
        if (MemAck) begin
          if (!wordQ)
            rdBuf_d = {8'h00, addrQ[0] ? MemRData[15:8] : MemRData[7:0]};
          else if (!addrQ[0])
            rdBuf_d = MemRData;
          else
            rdBuf_d = {rdBuf_q[15:8], MemRData[15:8]};
          state_d = misaligned ? S_PH2 : S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PH2: begin
        // Ack wins over timeout when both land in the final wait cycle.
        if (MemAck) begin
          rdBuf_d = {MemRData[7:0], rdBuf_q[7:0]};
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!writeQ) rdData_d = rdBuf_q;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        if (!writeQ) rdData_d = 16'hFFFF;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MemReq   = 1'b0;
    MemAddr  = '0;
    MemWE    = 1'b0;
    MemBE    = 2'b00;
    MemWData = '0;
    if (state_q == S_PH1 || state_q == S_PH2) begin
      MemReq  = 1'b1;
      MemAddr = addrQ[19:1];
      if (state_q == S_PH2) begin
        MemAddr  = addrQ[19:1] + 19'd1;
        MemBE    = 2'b01;
        MemWData = {8'h00, wdataQ[15:8]};
      end else if (wordQ && !addrQ[0]) begin
        MemBE    = 2'b11;
        MemWData = wdataQ;
      end else if (addrQ[0]) begin
        MemBE    = 2'b10;
        MemWData = {wdataQ[7:0], 8'h00};
      end else begin
        MemBE    = 2'b01;
        MemWData = {8'h00, wdataQ[7:0]};
      end
      MemWE = writeQ;
      if (wrProt) begin
        MemWE = 1'b0;
        MemBE = 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_ram_bridge.sv
// Directed self-checking bench for ram_bridge: one task per scenario, inline comparisons.
module tb_ram_bridge;

`ifdef RAM_BRIDGE_WRPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        FCLK = 1'b0;
  logic        RESETL;
  logic [19:0] ABus;
  logic        Write, Word;
  logic [15:0] WrData;
  logic [15:0] RdData;
  logic        Busy, TimeoutP, MemReq;
  logic        MemAck;
  logic [18:0] MemAddr;
  logic        MemWE;
  logic [1:0]  MemBE;
  logic [15:0] MemWData;
  logic [15:0] MemRData;

  int checks = 0;
  int errors = 0;
  int pulses;
  int extra;

  ram_bridge #(.TIMEOUT(64), .ROM_BASE(20'hE0000)) dut (
    .FCLK(FCLK), .RESETL(RESETL), .ABus(ABus), .Write(Write), .Word(Word),
    .WrData(WrData), .RdData(RdData), .Busy(Busy), .TimeoutP(TimeoutP),
    .MemReq(MemReq), .MemAck(MemAck), .MemAddr(MemAddr), .MemWE(MemWE),
    .MemBE(MemBE), .MemWData(MemWData), .MemRData(MemRData)
  );

  always #5 FCLK = ~FCLK;

  // Absolute time limit so a stuck bench still terminates.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    RESETL = 1'b1; ABus = 20'h00010; Write = 1'b0; Word = 1'b1;
    WrData = 16'h0; MemAck = 1'b0; MemRData = 16'h0;
    #1 RESETL = 1'b0;
    #2;
    checks++; if (RdData !== 16'h0) begin errors++; $display("[TB] FAIL reset_rddata: got %h expected 0000", RdData); end
    checks++; if ({Busy, TimeoutP, MemReq} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {Busy, TimeoutP, MemReq}); end
    checks++; if ({MemAddr, MemWE, MemBE, MemWData} !== 38'h0) begin errors++; $display("[TB] FAIL reset_mem: addr %h we %b be %b wd %h expected all 0", MemAddr, MemWE, MemBE, MemWData); end
    @(negedge FCLK); @(negedge FCLK);
    RESETL = 1'b1;
  endtask

  task automatic test_aligned_read();
    @(posedge FCLK); #1;
    checks++; if ({MemReq, Busy, MemWE} !== 3'b110) begin errors++; $display("[TB] FAIL ar_req: got %b expected 110", {MemReq, Busy, MemWE}); end
    checks++; if (MemAddr !== 19'h00008) begin errors++; $display("[TB] FAIL ar_addr: got %h expected 00008", MemAddr); end
    checks++; if (MemBE !== 2'b11) begin errors++; $display("[TB] FAIL ar_be: got %b expected 11", MemBE); end
    @(negedge FCLK); MemAck = 1'b1; MemRData = 16'hBEEF;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, Busy} !== 2'b01) begin errors++; $display("[TB] FAIL ar_done: req/busy %b expected 01", {MemReq, Busy}); end
    @(negedge FCLK); MemAck = 1'b0; MemRData = 16'h0;
    @(posedge FCLK); #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL ar_busy3: got %b expected 0", Busy); end
    checks++; if (RdData !== 16'hBEEF) begin errors++; $display("[TB] FAIL ar_rddata: got %h expected beef", RdData); end
    @(posedge FCLK); #1;
    checks++; if (MemReq !== 1'b0) begin errors++; $display("[TB] FAIL ar_norestart: req %b expected 0", MemReq); end
  endtask

  task automatic test_byte_read();
    @(negedge FCLK); ABus = 20'h00011; Word = 1'b0; Write = 1'b0;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, MemAddr, MemBE} !== {1'b1, 19'h00008, 2'b10}) begin errors++; $display("[TB] FAIL br_phase: req %b addr %h be %b expected 1 00008 10", MemReq, MemAddr, MemBE); end
    @(negedge FCLK); MemAck = 1'b1; MemRData = 16'h12AB;
    @(posedge FCLK);
    @(negedge FCLK); MemAck = 1'b0;
    @(posedge FCLK); #1;
    checks++; if ({Busy, RdData} !== {1'b0, 16'h0012}) begin errors++; $display("[TB] FAIL br_rddata: busy %b rd %h expected 0 0012", Busy, RdData); end
  endtask

  task automatic test_misaligned_write();
    @(negedge FCLK); ABus = 20'hFFFFF; Word = 1'b1; Write = 1'b1; WrData = 16'hA55A;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, MemAddr} !== {1'b1, 19'h7FFFF}) begin errors++; $display("[TB] FAIL mw_ph1_addr: req %b addr %h expected 1 7ffff", MemReq, MemAddr); end
    checks++; if ({MemWE, MemBE} !== (PROT ? 3'b000 : 3'b110)) begin errors++; $display("[TB] FAIL mw_ph1_be: we/be %b expected %b", {MemWE, MemBE}, PROT ? 3'b000 : 3'b110); end
    checks++; if (MemWData !== 16'h5A00) begin errors++; $display("[TB] FAIL mw_ph1_wd: got %h expected 5a00", MemWData); end
    @(negedge FCLK); MemAck = 1'b1;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, MemAddr, MemWE, MemBE} !== {1'b1, 19'h00000, 1'b1, 2'b01}) begin errors++; $display("[TB] FAIL mw_ph2: req %b addr %h we %b be %b expected 1 00000 1 01", MemReq, MemAddr, MemWE, MemBE); end
    checks++; if (MemWData !== 16'h00A5) begin errors++; $display("[TB] FAIL mw_ph2_wd: got %h expected 00a5", MemWData); end
    @(negedge FCLK); MemAck = 1'b0;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, MemAddr} !== {1'b1, 19'h00000}) begin errors++; $display("[TB] FAIL mw_ph2_hold: req %b addr %h expected 1 00000", MemReq, MemAddr); end
    @(negedge FCLK); MemAck = 1'b1;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, Busy} !== 2'b01) begin errors++; $display("[TB] FAIL mw_done: req/busy %b expected 01", {MemReq, Busy}); end
    @(negedge FCLK); MemAck = 1'b0;
    @(posedge FCLK); #1;
    checks++; if ({Busy, RdData} !== {1'b0, 16'h0012}) begin errors++; $display("[TB] FAIL mw_rdkeep: busy %b rd %h expected 0 0012", Busy, RdData); end
  endtask

  task automatic test_timeout();
    @(negedge FCLK); ABus = 20'h00020; Word = 1'b1; Write = 1'b0; WrData = 16'h0;
    pulses = 0;
    @(posedge FCLK); #1;
    for (int i = 1; i < 64; i++) begin
      @(posedge FCLK); #1;
      if (TimeoutP) pulses++;
    end
    checks++; if ({MemReq, pulses} !== {1'b1, 32'd0}) begin errors++; $display("[TB] FAIL to_wait63: req %b pulses %0d expected 1 0", MemReq, pulses); end
    @(posedge FCLK); #1;
    checks++; if ({TimeoutP, MemReq, Busy} !== 3'b101) begin errors++; $display("[TB] FAIL to_abort: tp/req/busy %b expected 101", {TimeoutP, MemReq, Busy}); end
    @(posedge FCLK); #1;
    checks++; if ({TimeoutP, Busy, RdData} !== {2'b00, 16'hFFFF}) begin errors++; $display("[TB] FAIL to_after: tp %b busy %b rd %h expected 0 0 ffff", TimeoutP, Busy, RdData); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge FCLK); #1;
      if (MemReq || TimeoutP) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL to_norestart: active cycles %0d expected 0", extra); end
    @(negedge FCLK); ABus = 20'h00022;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, MemAddr} !== {1'b1, 19'h00011}) begin errors++; $display("[TB] FAIL to_restart: req %b addr %h expected 1 00011", MemReq, MemAddr); end
    @(negedge FCLK); MemAck = 1'b1; MemRData = 16'h3344;
    @(posedge FCLK);
    @(negedge FCLK); MemAck = 1'b0;
    @(posedge FCLK); #1;
    checks++; if (RdData !== 16'h3344) begin errors++; $display("[TB] FAIL to_recover: got %h expected 3344", RdData); end
  endtask

  task automatic test_ack_on_last();
    @(negedge FCLK); ABus = 20'h00030; Word = 1'b1; Write = 1'b0;
    pulses = 0;
    @(posedge FCLK); #1;
    for (int i = 1; i < 64; i++) begin
      @(posedge FCLK); #1;
      if (TimeoutP) pulses++;
    end
    @(negedge FCLK); MemAck = 1'b1; MemRData = 16'h7788;
    @(posedge FCLK); #1;
    if (TimeoutP) pulses++;
    checks++; if ({TimeoutP, MemReq, Busy} !== 3'b001) begin errors++; $display("[TB] FAIL al_done: tp/req/busy %b expected 001", {TimeoutP, MemReq, Busy}); end
    @(negedge FCLK); MemAck = 1'b0;
    @(posedge FCLK); #1;
    if (TimeoutP) pulses++;
    checks++; if ({Busy, RdData, pulses} !== {1'b0, 16'h7788, 32'd0}) begin errors++; $display("[TB] FAIL al_rddata: busy %b rd %h pulses %0d expected 0 7788 0", Busy, RdData, pulses); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge FCLK); ABus = 20'h00041; Word = 1'b1; Write = 1'b0;
    @(posedge FCLK); #1;
    checks++; if ({MemAddr, MemBE} !== {19'h00020, 2'b10}) begin errors++; $display("[TB] FAIL rm_ph1: addr %h be %b expected 00020 10", MemAddr, MemBE); end
    @(negedge FCLK); MemAck = 1'b1; MemRData = 16'h9900;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, MemAddr, MemBE} !== {1'b1, 19'h00021, 2'b01}) begin errors++; $display("[TB] FAIL rm_ph2: req %b addr %h be %b expected 1 00021 01", MemReq, MemAddr, MemBE); end
    @(negedge FCLK); MemAck = 1'b0;
    #2 RESETL = 1'b0;
    #1;
    checks++; if ({RdData, Busy, TimeoutP, MemReq, MemAddr, MemWE, MemBE, MemWData} !== 57'h0) begin errors++; $display("[TB] FAIL rm_async: rd %h busy %b req %b addr %h be %b expected all 0", RdData, Busy, MemReq, MemAddr, MemBE); end
    @(negedge FCLK); RESETL = 1'b1;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, MemAddr, MemBE} !== {1'b1, 19'h00020, 2'b10}) begin errors++; $display("[TB] FAIL rm_reaccess: req %b addr %h be %b expected 1 00020 10", MemReq, MemAddr, MemBE); end
    @(negedge FCLK); MemAck = 1'b1; MemRData = 16'hAB00;
    @(posedge FCLK);
    @(negedge FCLK); MemRData = 16'h00CD;
    @(posedge FCLK);
    @(negedge FCLK); MemAck = 1'b0;
    @(posedge FCLK); #1;
    checks++; if ({Busy, RdData} !== {1'b0, 16'hCDAB}) begin errors++; $display("[TB] FAIL rm_rddata: busy %b rd %h expected 0 cdab", Busy, RdData); end
  endtask

  task automatic test_wrprot();
    @(negedge FCLK); ABus = 20'hE0000; Word = 1'b0; Write = 1'b1; WrData = 16'h3355;
    @(posedge FCLK); #1;
    checks++; if ({MemReq, MemAddr, MemWData} !== {1'b1, 19'h70000, 16'h0055}) begin errors++; $display("[TB] FAIL wp_rom_addr: req %b addr %h wd %h expected 1 70000 0055", MemReq, MemAddr, MemWData); end
    checks++; if ({MemWE, MemBE} !== (PROT ? 3'b000 : 3'b101)) begin errors++; $display("[TB] FAIL wp_rom_we: we/be %b expected %b", {MemWE, MemBE}, PROT ? 3'b000 : 3'b101); end
    @(negedge FCLK); MemAck = 1'b1;
    @(posedge FCLK);
    @(negedge FCLK); MemAck = 1'b0; ABus = 20'h00100;
    @(posedge FCLK);
    @(posedge FCLK); #1;
    checks++; if ({MemReq, MemWE, MemBE, MemAddr} !== {1'b1, 1'b1, 2'b01, 19'h00080}) begin errors++; $display("[TB] FAIL wp_ram_we: req %b we %b be %b addr %h expected 1 1 01 00080", MemReq, MemWE, MemBE, MemAddr); end
    @(negedge FCLK); MemAck = 1'b1;
    @(posedge FCLK);
    @(negedge FCLK); MemAck = 1'b0;
    @(posedge FCLK); #1;
    checks++; if ({Busy, RdData} !== {1'b0, 16'hCDAB}) begin errors++; $display("[TB] FAIL wp_rdkeep: busy %b rd %h expected 0 cdab", Busy, RdData); end
  endtask

  initial begin
    test_reset();
    test_aligned_read();
    test_byte_read();
    test_misaligned_write();
    test_timeout();
    test_ack_on_last();
    test_reset_mid_access();
    test_wrprot();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
